// File: rtl/masked_tag_cam_if.sv
// Bundle of update and search signals for masked_tag_cam.
// The master drives the requests; the slave (the CAM) drives the results.
interface masked_tag_cam_if #(
    parameter int unsigned ENTRIES     = 16,
    parameter int unsigned FIELD_COUNT = 2,
    parameter int unsigned FIELD_WIDTH = 4
);
    localparam int unsigned DW = FIELD_COUNT * FIELD_WIDTH;
    localparam int unsigned AW = $clog2(ENTRIES);

    logic                   op_valid;
    logic                   op_ready;
    logic [1:0]             op_code;
    logic [AW-1:0]          op_addr;
    logic [DW-1:0]          op_data;
    logic [FIELD_COUNT-1:0] op_mask;
    logic                   op_done;
    logic                   op_err;
    logic [AW-1:0]          op_addr_out;

    logic                   search_valid;
    logic [DW-1:0]          search_data;
    logic [FIELD_COUNT-1:0] search_mask;
    logic                   match_valid;
    logic                   match;
    logic [ENTRIES-1:0]     match_many;
    logic [AW-1:0]          match_addr;

    logic [AW:0]            occupancy;
    logic                   full;
    logic                   empty;

    modport master (
        output op_valid, op_code, op_addr, op_data, op_mask,
        output search_valid, search_data, search_mask,
        input  op_ready, op_done, op_err, op_addr_out,
        input  match_valid, match, match_many, match_addr,
        input  occupancy, full, empty
    );

    modport slave (
        input  op_valid, op_code, op_addr, op_data, op_mask,
        input  search_valid, search_data, search_mask,
        output op_ready, op_done, op_err, op_addr_out,
        output match_valid, match, match_many, match_addr,
        output occupancy, full, empty
    );
endinterface

// File: rtl/masked_tag_cam.sv
// Register-based CAM with per-field search masks, auto-allocating insert, delete/flush,
// registered search and occupancy. Define MTCAM_WR_BYPASS_EN so commit-edge searches see post-commit state.
module masked_tag_cam #(
    parameter int unsigned ENTRIES     = 16,
    parameter int unsigned FIELD_COUNT = 2,
    parameter int unsigned FIELD_WIDTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    masked_tag_cam_if.slave bus
);
    localparam int unsigned DW = FIELD_COUNT * FIELD_WIDTH;
    localparam int unsigned AW = $clog2(ENTRIES);

    localparam logic [1:0] OpInsert = 2'd0;
    localparam logic [1:0] OpWrite  = 2'd1;
    localparam logic [1:0] OpDelete = 2'd2;
    localparam logic [1:0] OpFlush  = 2'd3;

    typedef enum logic [0:0] {StIdle, StCommit} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             opc_q, opc_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          data_q, data_d;
    logic [FIELD_COUNT-1:0] mask_q, mask_d;
    logic                   err_q, err_d;

    logic [ENTRIES-1:0]     valid_q, valid_d;
    logic [DW-1:0]          storage_q [ENTRIES];
    logic [DW-1:0]          storage_d [ENTRIES];

    logic                   done_q, done_d;
    logic                   op_err_q, op_err_d;
    logic [AW-1:0]          addr_out_q, addr_out_d;

    logic                   match_valid_q, match_valid_d;
    logic                   match_q, match_d;
    logic [ENTRIES-1:0]     many_q, many_d;
    logic [AW-1:0]          maddr_q, maddr_d;
    logic [ENTRIES-1:0]     hits;

    logic [AW:0]            occ_q, occ_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;

    logic                   free_found;
    logic [AW-1:0]          free_idx;

    // An all-zero mask never hits, so a masked-off search cannot report stale entries.
    function automatic logic field_hit(input logic [DW-1:0]          ent,
                                       input logic [DW-1:0]          key,
                                       input logic [FIELD_COUNT-1:0] msk);
        logic h;
        h = |msk;
        for (int f = 0; f < int'(FIELD_COUNT); f++) begin
            if (msk[f] && (ent[f*FIELD_WIDTH +: FIELD_WIDTH] != key[f*FIELD_WIDTH +: FIELD_WIDTH])) begin
                h = 1'b0;
            end
        end
        return h;
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        err_d      = err_q;
        valid_d    = valid_q;
        storage_d  = storage_q;
        done_d     = 1'b0;
        op_err_d   = 1'b0;
        addr_out_d = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    state_d = StCommit;
                    opc_d   = bus.op_code;
                    addr_d  = (bus.op_code == OpInsert) ? free_idx : bus.op_addr;
                    data_d  = bus.op_data;
                    mask_d  = bus.op_mask;
                    err_d   = ((bus.op_code == OpInsert) && !free_found) ||
                              ((bus.op_code == OpFlush) && (bus.op_mask == '0));
                end
            end
            StCommit: begin
                state_d  = StIdle;
                done_d   = 1'b1;
                op_err_d = err_q;
                case (opc_q)
                    OpInsert: begin
                        if (!err_q) begin
                            storage_d[addr_q] = data_q;
                            valid_d[addr_q]   = 1'b1;
                            addr_out_d        = addr_q;
                        end
                    end
                    OpWrite: begin
                        storage_d[addr_q] = data_q;
                        valid_d[addr_q]   = 1'b1;
                        addr_out_d        = addr_q;
                    end
                    OpDelete: begin
                        valid_d[addr_q] = 1'b0;
                        addr_out_d      = addr_q;
                    end
                    OpFlush: begin
                        for (int e = 0; e < int'(ENTRIES); e++) begin
                            if (valid_q[e] && field_hit(storage_q[e], data_q, mask_q)) begin
                                valid_d[e] = 1'b0;
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        occ_d = '0;
        for (int e = 0; e < int'(ENTRIES); e++) begin
            occ_d = occ_d + (AW+1)'(valid_d[e]);
        end
        full_d  = (occ_d == (AW+1)'(ENTRIES));
        empty_d = (occ_d == '0);
    end

    always_comb begin
        hits = '0;
        for (int e = 0; e < int'(ENTRIES); e++) begin
`ifdef MTCAM_WR_BYPASS_EN
            hits[e] = valid_d[e] && field_hit(storage_d[e], bus.search_data, bus.search_mask);
`else
            hits[e] = valid_q[e] && field_hit(storage_q[e], bus.search_data, bus.search_mask);
`endif
        end
        maddr_d = '0;
        for (int e = int'(ENTRIES) - 1; e >= 0; e--) begin
            if (hits[e]) begin
                maddr_d = AW'(e);
            end
        end
        many_d        = hits;
        match_d       = |hits;
        match_valid_d = bus.search_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            opc_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            valid_q       <= '0;
            done_q        <= 1'b0;
            op_err_q      <= 1'b0;
            addr_out_q    <= '0;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            many_q        <= '0;
            maddr_q       <= '0;
            occ_q         <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            opc_q         <= opc_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            op_err_q      <= op_err_d;
            addr_out_q    <= addr_out_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            many_q        <= many_d;
            maddr_q       <= maddr_d;
            occ_q         <= occ_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

    // Contents are qualified by valid_q, so the array needs no reset.
    always_ff @(posedge clk) begin
        storage_q <= storage_d;
    end

    assign bus.op_ready    = (state_q == StIdle);
    assign bus.op_done     = done_q;
    assign bus.op_err      = op_err_q;
    assign bus.op_addr_out = addr_out_q;
    assign bus.match_valid = match_valid_q;
    assign bus.match       = match_q;
    assign bus.match_many  = many_q;
    assign bus.match_addr  = maddr_q;
    assign bus.occupancy   = occ_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
endmodule

// File: tb/tb_masked_tag_cam.sv
// Randomised self-checking bench for masked_tag_cam against an array-based reference model.
// Honours MTCAM_WR_BYPASS_EN for the commit-edge search expectation.
module tb_masked_tag_cam;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    masked_tag_cam_if bus ();
    masked_tag_cam dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic       ref_valid [16];
    logic [7:0] ref_data  [16];

    function automatic logic [15:0] ref_hits(input logic [7:0] key, input logic [1:0] mask);
        logic [15:0] r;
        for (int e = 0; e < 16; e++) begin
            r[e] = ref_valid[e] && (mask != 2'b00);
            if (mask[0] && (key[3:0] != ref_data[e][3:0])) r[e] = 1'b0;
            if (mask[1] && (key[7:4] != ref_data[e][7:4])) r[e] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_occ();
        int n = 0;
        for (int e = 0; e < 16; e++) n += ref_valid[e] ? 1 : 0;
        return 5'(n);
    endfunction

    function automatic logic [3:0] lowest(input logic [15:0] h);
        logic [3:0] r = 4'd0;
        for (int i = 15; i >= 0; i--) if (h[i]) r = 4'(i);
        return r;
    endfunction

    task automatic ref_op(input logic [1:0] code, input logic [3:0] addr, input logic [7:0] data,
                          input logic [1:0] mask, output logic err, output logic [3:0] aout);
        logic [15:0] h;
        int free;
        err = 1'b0;
        aout = 4'd0;
        case (code)
            2'd0: begin
                free = -1;
                for (int e = 15; e >= 0; e--) if (!ref_valid[e]) free = e;
                if (free < 0) err = 1'b1;
                else begin
                    ref_valid[free] = 1'b1;
                    ref_data[free] = data;
                    aout = 4'(free);
                end
            end
            2'd1: begin ref_valid[addr] = 1'b1; ref_data[addr] = data; aout = addr; end
            2'd2: begin ref_valid[addr] = 1'b0; aout = addr; end
            default: begin
                err = (mask == 2'b00);
                h = ref_hits(data, mask);
                for (int e = 0; e < 16; e++) if (h[e]) ref_valid[e] = 1'b0;
            end
        endcase
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0; bus.op_code = 2'd0; bus.op_addr = 4'd0;
        bus.op_data = 8'd0; bus.op_mask = 2'd0;
        bus.search_valid = 1'b0; bus.search_data = 8'd0; bus.search_mask = 2'd0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int e = 0; e < 16; e++) ref_valid[e] = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] code, input logic [3:0] addr, input logic [7:0] data,
                         input logic [1:0] mask, output logic done, output logic err,
                         output logic [3:0] aout);
        int n = 0;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = code; bus.op_addr = addr;
        bus.op_data = data; bus.op_mask = mask;
        while (bus.op_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.op_valid = 1'b0;
        done = 1'b0; err = 1'b0; aout = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (bus.op_done === 1'b1) begin
                done = 1'b1; err = bus.op_err; aout = bus.op_addr_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_search(input logic [7:0] key, input logic [1:0] mask);
        @(negedge clk);
        bus.search_valid = 1'b1; bus.search_data = key; bus.search_mask = mask;
        @(negedge clk);
        bus.search_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.op_ready); end
        total++; if (bus.op_done !== 1'b0 || bus.op_err !== 1'b0 || bus.op_addr_out !== 4'd0) begin
            bad++; $display("FAIL rst_op got=%b%b%h exp=000", bus.op_done, bus.op_err, bus.op_addr_out); end
        total++; if (bus.match_valid !== 1'b0 || bus.match !== 1'b0 || bus.match_many !== 16'd0 ||
                     bus.match_addr !== 4'd0) begin
            bad++; $display("FAIL rst_match got=%b%b%h%h exp=0", bus.match_valid, bus.match,
                            bus.match_many, bus.match_addr); end
        total++; if (bus.occupancy !== 5'd0 || bus.full !== 1'b0 || bus.empty !== 1'b1) begin
            bad++; $display("FAIL rst_occ got=%0d/%b/%b exp=0/0/1", bus.occupancy, bus.full, bus.empty); end
        do_search(8'h00, 2'b11);
        total++; if (bus.match_valid !== 1'b1 || bus.match !== 1'b0 || bus.match_many !== 16'd0) begin
            bad++; $display("FAIL rst_search got=%b%b%h exp=1 0 0000", bus.match_valid, bus.match, bus.match_many); end
    endtask

    task automatic test_insert();
        logic d, e, ee; logic [3:0] a, ea;
        for (int k = 0; k < 3; k++) begin
            ref_op(2'd0, 4'd0, 8'h12, 2'b00, ee, ea);
            do_op(2'd0, 4'd0, 8'h12, 2'b00, d, e, a);
            total++; if (d !== 1'b1 || e !== ee || a !== ea || a !== 4'(k)) begin
                bad++; $display("FAIL insert%0d got=%b%b%h exp=1%b%h", k, d, e, a, ee, ea); end
        end
        total++; if (bus.occupancy !== ref_occ()) begin
            bad++; $display("FAIL insert_occ got=%0d exp=%0d", bus.occupancy, ref_occ()); end
        do_search(8'h12, 2'b11);
        total++; if (bus.match_many !== ref_hits(8'h12, 2'b11) || bus.match_addr !== 4'd0) begin
            bad++; $display("FAIL insert_search got=%h/%h exp=%h/0", bus.match_many, bus.match_addr,
                            ref_hits(8'h12, 2'b11)); end
    endtask

    task automatic test_mask();
        logic [1:0] masks [3];
        masks[0] = 2'b01; masks[1] = 2'b10; masks[2] = 2'b00;
        for (int k = 0; k < 3; k++) begin
            do_search(8'hB2, masks[k]);
            total++; if (bus.match !== (|ref_hits(8'hB2, masks[k])) ||
                         bus.match_many !== ref_hits(8'hB2, masks[k])) begin
                bad++; $display("FAIL mask_%b got=%b/%h exp=%h", masks[k], bus.match, bus.match_many,
                                ref_hits(8'hB2, masks[k])); end
        end
    endtask

    task automatic test_delete();
        logic d, e, ee; logic [3:0] a, ea;
        for (int k = 0; k < 2; k++) begin
            ref_op(2'd2, 4'd2, 8'h00, 2'b00, ee, ea);
            do_op(2'd2, 4'd2, 8'h00, 2'b00, d, e, a);
            total++; if (d !== 1'b1 || e !== 1'b0 || a !== 4'd2 || bus.occupancy !== ref_occ()) begin
                bad++; $display("FAIL delete%0d got=%b%b%h occ=%0d exp=102 occ=%0d", k, d, e, a,
                                bus.occupancy, ref_occ()); end
            do_search(8'h12, 2'b11);
            total++; if (bus.match_many !== ref_hits(8'h12, 2'b11)) begin
                bad++; $display("FAIL delete_search got=%h exp=%h", bus.match_many, ref_hits(8'h12, 2'b11)); end
        end
    endtask

    task automatic test_commit_edge();
        logic ee; logic [3:0] ea; logic [15:0] pre, post, exp;
        pre = ref_hits(8'h12, 2'b11);
        ref_op(2'd2, 4'd1, 8'h00, 2'b00, ee, ea);
        post = ref_hits(8'h12, 2'b11);
`ifdef MTCAM_WR_BYPASS_EN
        exp = post;
`else
        exp = pre;
`endif
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 2'd2; bus.op_addr = 4'd1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        total++; if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL commit_ready got=%b exp=0", bus.op_ready); end
        bus.search_valid = 1'b1; bus.search_data = 8'h12; bus.search_mask = 2'b11;
        @(negedge clk);
        bus.search_valid = 1'b0;
        total++; if (bus.op_done !== 1'b1 || bus.match_valid !== 1'b1 || bus.match_many !== exp) begin
            bad++; $display("FAIL commit_edge got=%b%b%h exp=11%h", bus.op_done, bus.match_valid,
                            bus.match_many, exp); end
        do_search(8'h12, 2'b11);
        total++; if (bus.match_many !== post) begin
            bad++; $display("FAIL commit_after got=%h exp=%h", bus.match_many, post); end
    endtask

    task automatic test_back_to_back();
        logic ee; logic [3:0] ea0, ea1;
        ref_op(2'd0, 4'd0, 8'hA1, 2'b00, ee, ea0);
        ref_op(2'd0, 4'd0, 8'hA2, 2'b00, ee, ea1);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 2'd0; bus.op_data = 8'hA1;
        @(negedge clk);
        bus.op_data = 8'hA2;
        total++; if (bus.op_ready !== 1'b0 || bus.op_done !== 1'b0) begin
            bad++; $display("FAIL b2b_commit got=%b%b exp=00", bus.op_ready, bus.op_done); end
        @(negedge clk);
        total++; if (bus.op_done !== 1'b1 || bus.op_addr_out !== ea0 || bus.op_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%b%h%b exp=1%h1", bus.op_done, bus.op_addr_out, bus.op_ready, ea0); end
        @(negedge clk);
        bus.op_valid = 1'b0;
        total++; if (bus.op_done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", bus.op_done); end
        @(negedge clk);
        total++; if (bus.op_done !== 1'b1 || bus.op_addr_out !== ea1) begin
            bad++; $display("FAIL b2b_second got=%b%h exp=1%h", bus.op_done, bus.op_addr_out, ea1); end
    endtask

    task automatic test_write();
        logic d, e, ee; logic [3:0] a, ea;
        logic [7:0] vals [2];
        vals[0] = 8'h34; vals[1] = 8'h35;
        for (int k = 0; k < 2; k++) begin
            ref_op(2'd1, 4'd5, vals[k], 2'b00, ee, ea);
            do_op(2'd1, 4'd5, vals[k], 2'b00, d, e, a);
            total++; if (d !== 1'b1 || e !== 1'b0 || a !== 4'd5 || bus.occupancy !== ref_occ()) begin
                bad++; $display("FAIL write%0d got=%b%b%h occ=%0d exp=105 occ=%0d", k, d, e, a,
                                bus.occupancy, ref_occ()); end
        end
        do_search(8'h35, 2'b11);
        total++; if (bus.match_many !== ref_hits(8'h35, 2'b11) || bus.match_addr !== 4'd5) begin
            bad++; $display("FAIL write_search got=%h/%h exp=%h/5", bus.match_many, bus.match_addr,
                            ref_hits(8'h35, 2'b11)); end
    endtask

    task automatic test_fill_flush();
        logic d, e, ee; logic [3:0] a, ea, nib; logic [7:0] dat;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 0 && k < 15) nib = 4'h2;
            else begin nib = 4'($urandom_range(0, 14)); if (nib >= 4'h2) nib = nib + 4'h1; end
            dat = {4'($urandom_range(0, 15)), nib};
            ref_op(2'd0, 4'd0, dat, 2'b00, ee, ea);
            do_op(2'd0, 4'd0, dat, 2'b00, d, e, a);
            total++; if (d !== 1'b1 || e !== 1'b0 || a !== ea) begin
                bad++; $display("FAIL fill%0d got=%b%b%h exp=10%h", k, d, e, a, ea); end
        end
        total++; if (bus.full !== 1'b1 || bus.occupancy !== 5'd16 || bus.empty !== 1'b0) begin
            bad++; $display("FAIL full got=%b/%0d exp=1/16", bus.full, bus.occupancy); end
        ref_op(2'd0, 4'd0, 8'h77, 2'b00, ee, ea);
        do_op(2'd0, 4'd0, 8'h77, 2'b00, d, e, a);
        total++; if (d !== 1'b1 || e !== 1'b1 || a !== 4'd0 || bus.occupancy !== 5'd16) begin
            bad++; $display("FAIL insert_full got=%b%b%h occ=%0d exp=110 occ=16", d, e, a, bus.occupancy); end
        ref_op(2'd3, 4'd0, 8'h02, 2'b01, ee, ea);
        do_op(2'd3, 4'd0, 8'h02, 2'b01, d, e, a);
        total++; if (d !== 1'b1 || e !== 1'b0 || a !== 4'd0 || bus.occupancy !== 5'd11 ||
                     bus.occupancy !== ref_occ() || bus.full !== 1'b0) begin
            bad++; $display("FAIL flush got=%b%b%h occ=%0d exp=100 occ=11", d, e, a, bus.occupancy); end
        do_search(8'h02, 2'b01);
        total++; if (bus.match !== 1'b0 || bus.match_many !== 16'd0) begin
            bad++; $display("FAIL flush_search got=%b/%h exp=0/0000", bus.match, bus.match_many); end
        ref_op(2'd3, 4'd0, 8'h00, 2'b00, ee, ea);
        do_op(2'd3, 4'd0, 8'h00, 2'b00, d, e, a);
        total++; if (d !== 1'b1 || e !== 1'b1 || a !== 4'd0 || bus.occupancy !== 5'd11) begin
            bad++; $display("FAIL flush_mask0 got=%b%b%h occ=%0d exp=110 occ=11", d, e, a, bus.occupancy); end
    endtask

    task automatic test_random();
        logic d, e, ee; logic [3:0] a, ea, addr; logic [1:0] code, mask; logic [7:0] dat; logic [15:0] h;
        for (int it = 0; it < 250; it++) begin
            code = 2'($urandom_range(0, 3));
            if (code == 2'd3 && $urandom_range(0, 1) == 0) code = 2'd0;
            addr = 4'($urandom_range(0, 15));
            dat  = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
            mask = 2'($urandom_range(0, 3));
            ref_op(code, addr, dat, mask, ee, ea);
            do_op(code, addr, dat, mask, d, e, a);
            total++; if (d !== 1'b1 || e !== ee || a !== ea) begin
                bad++; $display("FAIL rand_op%0d code=%0d got=%b%b%h exp=1%b%h", it, code, d, e, a, ee, ea); end
            total++; if (bus.occupancy !== ref_occ() || bus.full !== (ref_occ() == 5'd16) ||
                         bus.empty !== (ref_occ() == 5'd0)) begin
                bad++; $display("FAIL rand_occ%0d got=%0d exp=%0d", it, bus.occupancy, ref_occ()); end
            dat  = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
            mask = 2'($urandom_range(0, 3));
            h = ref_hits(dat, mask);
            do_search(dat, mask);
            total++; if (bus.match_valid !== 1'b1 || bus.match_many !== h || bus.match !== (|h) ||
                         bus.match_addr !== lowest(h)) begin
                bad++; $display("FAIL rand_search%0d got=%h/%b/%h exp=%h/%b/%h", it, bus.match_many,
                                bus.match, bus.match_addr, h, |h, lowest(h)); end
        end
    endtask

    task automatic test_reset_mid_commit();
        logic seen = 1'b0;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 2'd0; bus.op_data = 8'h55;
        @(negedge clk);
        bus.op_valid = 1'b0;
        #1 rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin @(negedge clk); seen = seen | (bus.op_done === 1'b1); end
        rst_n = 1'b1;
        for (int e = 0; e < 16; e++) ref_valid[e] = 1'b0;
        for (int k = 0; k < 4; k++) begin @(negedge clk); seen = seen | (bus.op_done === 1'b1); end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_done got=1 exp=0"); end
        total++; if (bus.empty !== 1'b1 || bus.op_ready !== 1'b1 || bus.occupancy !== ref_occ()) begin
            bad++; $display("FAIL midrst_state got=%b%b occ=%0d exp=11 occ=0", bus.empty, bus.op_ready,
                            bus.occupancy); end
        do_search(8'h55, 2'b11);
        total++; if (bus.match !== 1'b0) begin bad++; $display("FAIL midrst_search got=%b exp=0", bus.match); end
    endtask

    initial begin
        idle_inputs();
        for (int e = 0; e < 16; e++) begin ref_valid[e] = 1'b0; ref_data[e] = 8'h00; end
        test_reset();
        test_insert();
        test_mask();
        test_delete();
        test_commit_edge();
        test_back_to_back();
        test_write();
        test_fill_flush();
        test_random();
        test_reset_mid_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
